paralelo_serial_tx: RTL and testbench

//  Transmit side of the serial link: serialises parallel bytes onto a 1-bit line at 8 bits per symbol, MSB first.

---
 rtl/paralelo_serial_pkg.sv | 21 ++
 rtl/paralelo_serial_tx_sym_shifter.sv | 34 +++
 rtl/paralelo_serial_tx.sv | 92 +++++++++
 tb/tb_paralelo_serial_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver:
// comma symbol, default training length and link state encoding.
package paralelo_serial_pkg;

  localparam int unsigned SYM_W      = 8;
  localparam int unsigned BIT_CNT_W  = $clog2(SYM_W);
  localparam logic [7:0]  COMMA_SYM  = 8'hBC;
  localparam int unsigned N_SYNC_DEF = 4;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;

  // True when a symbol equals the comma (receiver treats it as idle)
  function automatic logic is_comma(input logic [SYM_W-1:0] sym,
                                    input logic [SYM_W-1:0] comma);
    return sym == comma;
  endfunction

endpackage

// File: rtl/paralelo_serial_tx_sym_shifter.sv
// Symbol shifter: free-running bit counter plus load/shift register.
// Loads sym_c on the boundary edge (bit_cnt==7), otherwise shifts left MSB-first.
module paralelo_serial_tx_sym_shifter
  import paralelo_serial_pkg::*;
(
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [SYM_W-1:0] sym_c,
  output logic             boundary_c,
  output logic             data_out
);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [SYM_W-1:0]     shreg;

  assign boundary_c = (bit_cnt == BIT_CNT_W'(SYM_W - 1));
  assign data_out   = shreg[SYM_W-1];

  // Reset parks the counter on the boundary so the first edge loads a symbol
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt <= BIT_CNT_W'(SYM_W - 1);
      shreg   <= '0;
    end else begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (boundary_c) begin
        shreg <= sym_c;
      end else begin
        shreg <= {shreg[SYM_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Serial link transmitter: trains the receiver with commas, then sends one
// byte per 8-bit symbol slot (comma fill when idle), MSB first.
module paralelo_serial_tx
  import paralelo_serial_pkg::*;
#(
  parameter logic [7:0]  COMMA  = COMMA_SYM,
  parameter int unsigned N_SYNC = N_SYNC_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       resync,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
  output logic       comma_err_out
);

  localparam int unsigned       SYNC_W    = $clog2(N_SYNC + 1);
  localparam logic [SYNC_W-1:0] SYNC_DONE = SYNC_W'(N_SYNC);

  link_state_e       state_q, state_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              resync_pend_q, resync_pend_d;
  logic              active_d;
  logic              comma_err_d;
  logic [SYM_W-1:0]  sym_c;
  logic              boundary_c;
  logic              trained_c;
  logic              accept_c;

  paralelo_serial_tx_sym_shifter u_shifter (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .sym_c      (sym_c),
    .boundary_c (boundary_c),
    .data_out   (data_out)
  );

  assign trained_c = (state_q == ACTIVE) || (sync_cnt_q == SYNC_DONE);
  assign ready_out = boundary_c & ~resync_pend_q & ~resync & trained_c;
  assign accept_c  = valid_in & ready_out;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q       <= TRAIN;
      sync_cnt_q    <= '0;
      resync_pend_q <= 1'b0;
      active_out    <= 1'b0;
      comma_err_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_cnt_q    <= sync_cnt_d;
      resync_pend_q <= resync_pend_d;
      active_out    <= active_d;
      comma_err_out <= comma_err_d;
    end
  end

  // Next-state and symbol selection; decisions only take effect on boundaries
  always_comb begin
    state_d       = state_q;
    sync_cnt_d    = sync_cnt_q;
    resync_pend_d = resync_pend_q;
    active_d      = active_out;
    comma_err_d   = 1'b0;
    sym_c         = COMMA;

    if (boundary_c) begin
      if (resync_pend_q || resync) begin
        // This boundary's comma is the first of the new training run
        state_d       = TRAIN;
        sync_cnt_d    = SYNC_W'(1);
        resync_pend_d = 1'b0;
        active_d      = 1'b0;
      end else if (trained_c) begin
        state_d  = ACTIVE;
        active_d = 1'b1;
        if (accept_c) begin
          sym_c       = data_in;
          comma_err_d = is_comma(data_in, COMMA);
        end
      end else begin
        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
      end
    end else if (resync) begin
      resync_pend_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: directed vectors, resync/reset
// corners and random traffic against a symbol-queue reference model.
module tb_paralelo_serial_tx;

  localparam int unsigned N_SYNC = 4;
  localparam logic [7:0]  COMMA  = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       resync;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic       comma_err_out;

  paralelo_serial_tx #(.COMMA(COMMA), .N_SYNC(N_SYNC)) dut (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .resync        (resync),
    .ready_out     (ready_out),
    .data_out      (data_out),
    .active_out    (active_out),
    .comma_err_out (comma_err_out)
  );

  always #5 clk_32f = ~clk_32f;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of line bits still to be sent, plus link bookkeeping
  logic       m_q[$];
  int         m_commas;
  logic       m_active;
  logic       m_pend;
  logic       m_err;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_sr;

  logic        last_acc, last_dout, last_rdy, last_err, last_act;
  logic [31:0] dsr;

  typedef struct {
    logic [7:0] data;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  int waited;
  int first_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: entered at a falling edge with inputs already driven
  task automatic tick();
    logic       boundary, acc, exp_dout, exp_rdy;
    logic [7:0] sym;
    #1;
    boundary = (m_q.size() <= 1);
    exp_dout = (m_q.size() > 0) ? m_q[0] : 1'b0;
    exp_rdy  = boundary && !m_pend && !resync && (m_active || m_commas == N_SYNC);
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("ready_out", 32'(ready_out), 32'(exp_rdy));
    chk("active_out", 32'(active_out), 32'(m_active));
    chk("comma_err_out", 32'(comma_err_out), 32'(m_err));
    last_dout = data_out;
    last_rdy  = ready_out;
    last_err  = comma_err_out;
    last_act  = active_out;
    dsr       = {dsr[30:0], data_out};
    acc       = valid_in && exp_rdy;
    last_acc  = acc;
    if (m_q.size() > 0) begin
      rx_sr = {rx_sr[6:0], data_out};
      if (m_q.size() == 1 && rx_sr != COMMA) rx_q.push_back(rx_sr);
      void'(m_q.pop_front());
    end
    m_err = 1'b0;
    if (boundary) begin
      sym = COMMA;
      if (m_pend || resync) begin
        m_commas = 1;
        m_active = 1'b0;
        m_pend   = 1'b0;
      end else if (m_active || m_commas == N_SYNC) begin
        m_active = 1'b1;
        if (acc) begin
          sym   = data_in;
          m_err = (data_in == COMMA);
          if (data_in != COMMA) tx_q.push_back(data_in);
        end
      end else begin
        m_commas++;
      end
      for (int i = 7; i >= 0; i--) m_q.push_back(sym[i]);
    end else if (resync) begin
      m_pend = 1'b1;
    end
    @(negedge clk_32f);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_active_out", 32'(active_out), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd0);
    chk("rst_comma_err", 32'(comma_err_out), 32'd0);
    m_q.delete();
    tx_q.delete();
    rx_q.delete();
    m_commas = 0;
    m_active = 1'b0;
    m_pend   = 1'b0;
    m_err    = 1'b0;
    rx_sr    = '0;
    valid_in = 1'b0;
    resync   = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  // Four commas, ready first high on the last bit of the fourth, then ACTIVE
  task automatic train_check();
    int fr;
    fr = -1;
    valid_in = 1'b0;
    resync   = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (last_rdy && fr < 0) fr = t;
      if (t == 32) begin
        chk("train_commas", dsr, 32'hBCBCBCBC);
        chk("train_active_low", 32'(last_act), 32'd0);
      end
      if (t == 33) chk("train_active_rise", 32'(last_act), 32'd1);
    end
    chk("first_ready_cycle", 32'(fr), 32'd32);
  endtask

  task automatic offer(input logic [7:0] d);
    data_in  = d;
    valid_in = 1'b1;
    waited   = 0;
    do begin
      tick();
      waited++;
    end while (!last_acc && waited < 64);
    chk("accept_wait", 32'(last_acc), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0};
    vecs[2] = '{8'hBC, 1'b1};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h81, 1'b0};

    reset    = 1'b1;
    valid_in = 1'b0;
    resync   = 1'b0;
    data_in  = '0;
    dsr      = '0;
    #2;
    apply_reset();
    train_check();

    // Back-to-back table: each byte held until accepted, no idle gap between
    for (int i = 0; i < 6; i++) begin
      offer(vecs[i].data);
      if (i > 0) begin
        chk("prev_byte", 32'(dsr[7:0]), 32'(vecs[i-1].data));
        chk("no_gap", 32'(waited), 32'd1);
      end
      valid_in = 1'b0;
      tick();
      chk("comma_err_pulse", 32'(last_err), 32'(vecs[i].exp_err));
      tick();
      chk("comma_err_width", 32'(last_err), 32'd0);
      repeat (5) tick();
    end
    tick();
    chk("last_byte", 32'(dsr[7:0]), 32'(vecs[5].data));

    // Resync mid-symbol (bit 3 of 0x5A): symbol completes, then retrain
    offer(8'h5A);
    valid_in = 1'b0;
    repeat (3) tick();
    resync = 1'b1;
    tick();
    resync    = 1'b0;
    first_rdy = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (last_rdy && first_rdy < 0) first_rdy = t;
      if (t == 4)  chk("resync_byte_whole", 32'(dsr[7:0]), 32'h5A);
      if (t == 5)  chk("resync_active_fall", 32'(last_act), 32'd0);
      if (t == 36) chk("resync_commas", dsr, 32'hBCBCBCBC);
      if (t == 37) chk("resync_active_rise", 32'(last_act), 32'd1);
    end
    chk("resync_first_ready", 32'(first_rdy), 32'd36);

    // Resync landing on a boundary blocks the accept there
    waited = 0;
    while (m_q.size() != 1 && waited < 16) begin
      tick();
      waited++;
    end
    data_in  = 8'h11;
    valid_in = 1'b1;
    resync   = 1'b1;
    tick();
    chk("resync_bnd_ready", 32'(last_rdy), 32'd0);
    resync   = 1'b0;
    valid_in = 1'b0;
    tick();
    chk("resync_bnd_active", 32'(last_act), 32'd0);
    repeat (40) tick();

    // Random traffic; source holds data until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!(valid_in && !last_acc)) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = ($urandom_range(0, 15) == 0) ? COMMA : 8'($urandom);
      end
      resync = ($urandom_range(0, 299) == 0);
      tick();
    end
    valid_in = 1'b0;
    resync   = 1'b0;
    repeat (24) tick();

    // Bytes recovered from the line must equal the accepted non-comma bytes
    chk("rx_count", 32'(rx_q.size()), 32'(tx_q.size()));
    for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++)
      chk("rx_byte", 32'(rx_q[i]), 32'(tx_q[i]));

    // Reset mid-symbol drops the line at once, then training repeats
    offer(8'hFF);
    valid_in = 1'b0;
    repeat (4) tick();
    chk("pre_reset_line", 32'(data_out), 32'd1);
    apply_reset();
    train_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
